// File: rtl/keccak_block_padder.sv
// rtl/keccak_block_padder.sv - SHA-3 input stage: packs 32-bit words into rate blocks and applies pad10*1
//
// Purpose
//   Collects message words into a RATE_WORDS x 32-bit rate block, pads the final
//   word (PAD_FIRST after the last message byte, PAD_LAST in the last byte of the
//   final block) and hands each full block to the permutation with an
//   o_out_ready / i_f_ack handshake. After the final block is consumed the stage
//   refuses input until reset.
//
// Ports
//   i_clk          clock
//   i_reset        synchronous active-high reset
//   i_in           message word, byte 0 in bits [31:24]
//   i_byte_num     valid bytes in a last word (0..3), from the MSB down
//   i_is_last      word is the final one of the message
//   i_in_ready     word valid
//   o_buffer_full  1 = the word presented this cycle is not accepted
//   o_out          rate block, word 0 in the top 32 bits
//   o_out_ready    o_out holds a complete block
//   o_last_block   qualifies o_out_ready: this is the final padded block
//   i_f_ack        permutation has consumed o_out

module keccak_block_padder #(
    parameter int         RATE_WORDS = 18,
    parameter logic [7:0] PAD_FIRST  = 8'h06,
    parameter logic [7:0] PAD_LAST   = 8'h80
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [31:0]               i_in,
    input  logic [1:0]                i_byte_num,
    input  logic                      i_is_last,
    input  logic                      i_in_ready,
    output logic                      o_buffer_full,
    output logic [RATE_WORDS*32-1:0]  o_out,
    output logic                      o_out_ready,
    output logic                      o_last_block,
    input  logic                      i_f_ack
);

    localparam int CNT_W = $clog2(RATE_WORDS + 1);
    localparam int IDX_W = $clog2(RATE_WORDS);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RATE_WORDS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATE_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ABSORB    = 2'd0,
        PAD       = 2'd1,
        WAIT_LAST = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_buf [RATE_WORDS];

    logic             w_full;
    logic             w_at_last_slot;
    logic [IDX_W-1:0] w_idx;

    assign w_full         = (r_cnt == FULL_CNT);
    assign w_at_last_slot = (r_cnt == LAST_IDX);
    assign w_idx          = r_cnt[IDX_W-1:0];

    assign o_buffer_full  = w_full | (r_state != ABSORB);
    assign o_out_ready    = w_full;
    assign o_last_block   = w_full & (r_state == WAIT_LAST);

    // Keeps the first nb bytes, places PAD_FIRST right after them and zeroes the
    // rest. When the word is also the last slot of the block the closing pad bit
    // lands in byte 3, possibly in the same byte as PAD_FIRST.
    function automatic logic [31:0] pad_word(
        input logic [31:0] d,
        input logic [1:0]  nb,
        input logic        last_slot
    );
        logic [31:0] w;
        case (nb)
            2'd0:    w = {PAD_FIRST, 24'h000000};
            2'd1:    w = {d[31:24], PAD_FIRST, 16'h0000};
            2'd2:    w = {d[31:16], PAD_FIRST, 8'h00};
            default: w = {d[31:8], PAD_FIRST};
        endcase
        if (last_slot) begin
            w[7:0] = w[7:0] | PAD_LAST;
        end
        return w;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ABSORB;
            r_cnt   <= '0;
            for (int i = 0; i < RATE_WORDS; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            case (r_state)
                ABSORB: begin
                    if (w_full) begin
                        // Block is held until acknowledged; the refill starts
                        // on the following cycle, never in the ack cycle.
                        if (i_f_ack) begin
                            r_cnt <= '0;
                        end
                    end else if (i_in_ready) begin
                        r_cnt <= r_cnt + CNT_ONE;
                        if (i_is_last) begin
                            r_buf[w_idx] <= pad_word(i_in, i_byte_num, w_at_last_slot);
                            r_state      <= w_at_last_slot ? WAIT_LAST : PAD;
                        end else begin
                            r_buf[w_idx] <= i_in;
                        end
                    end
                end

                PAD: begin
                    // Zero-fill the remainder of the final block, one word per
                    // cycle, closing it with PAD_LAST in the last byte.
                    r_buf[w_idx] <= w_at_last_slot ? {24'h000000, PAD_LAST} : 32'h0;
                    r_cnt        <= r_cnt + CNT_ONE;
                    if (w_at_last_slot) begin
                        r_state <= WAIT_LAST;
                    end
                end

                WAIT_LAST: begin
                    if (w_full && i_f_ack) begin
                        r_cnt   <= '0;
                        r_state <= DONE;
                    end
                end

                DONE: begin
                    r_state <= DONE;
                end

                default: begin
                    r_state <= ABSORB;
                end
            endcase
        end
    end

    always_comb begin
        o_out = '0;
        for (int i = 0; i < RATE_WORDS; i++) begin
            o_out[RATE_WORDS*32-1-32*i -: 32] = r_buf[i];
        end
    end

endmodule

// File: tb/tb_keccak_block_padder.sv
// tb/tb_keccak_block_padder.sv - self-checking bench for keccak_block_padder

module tb_keccak_block_padder;

    logic         clk;
    logic         rst;
    logic [31:0]  din;
    logic [1:0]   nb;
    logic         is_last;
    logic         in_ready;
    logic         f_ack;
    logic         buffer_full;
    logic [575:0] dout;
    logic         out_ready;
    logic         last_block;

    int n_pass;
    int n_total;

    keccak_block_padder dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_in          (din),
        .i_byte_num    (nb),
        .i_is_last     (is_last),
        .i_in_ready    (in_ready),
        .o_buffer_full (buffer_full),
        .o_out         (dout),
        .o_out_ready   (out_ready),
        .o_last_block  (last_block),
        .i_f_ack       (f_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          k;
        logic [31:0] data;
        logic [1:0]  nb;
        logic [31:0] exp_k;
        logic [31:0] exp_17;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [575:0] act, input logic [575:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_ready = 1'b0;
        is_last  = 1'b0;
        f_ack    = 1'b0;
        nb       = 2'd0;
        din      = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] fill(input int i);
        return {8'hA5, 8'(i), 16'h5A5A};
    endfunction

    task automatic wait_ready(output int lat);
        lat = 1;
        while (!out_ready && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_entry(input vec_t v, input int id);
        logic [575:0] exp;
        int lat;
        string tag;
        tag = $sformatf("vec%0d", id);
        do_reset();
        for (int i = 0; i < v.k; i++) begin
            din = fill(i); in_ready = 1'b1; is_last = 1'b0;
            tick();
        end
        din = v.data; nb = v.nb; is_last = 1'b1; in_ready = 1'b1;
        tick();
        idle_inputs();
        wait_ready(lat);
        check({tag, "_latency"}, lat, v.exp_lat);
        exp = '0;
        for (int j = 0; j < v.k; j++) exp[575-32*j -: 32] = fill(j);
        exp[575-32*v.k -: 32] = v.exp_k;
        exp[31:0] = exp[31:0] | v.exp_17;
        check({tag, "_block"}, dout, exp);
        check({tag, "_last_block"}, last_block, 1'b1);
        f_ack = 1'b1;
        tick();
        f_ack = 1'b0;
        check({tag, "_done_ready"}, out_ready, 1'b0);
        check({tag, "_done_full"}, buffer_full, 1'b1);
        for (int c = 0; c < 3; c++) begin
            din = $urandom; in_ready = 1'b1; is_last = c[0]; nb = 2'd3;
            tick();
        end
        idle_inputs();
        check({tag, "_done_ignore"}, {out_ready, buffer_full}, 2'b01);
        check({tag, "_done_hold"}, dout, exp);
    endtask

    // Reference model: message as a byte stream, padded by the multi-rate rule
    // (append 0x06, zero-fill to a 72-byte boundary, OR 0x80 into the last byte).
    task automatic run_random(input int nbytes, input int id);
        logic [7:0]   msg[$];
        logic [7:0]   padded[$];
        logic [31:0]  words[$];
        logic [1:0]   last_nb;
        logic [575:0] eb;
        int nfull, nblk, wi, blk, delay, cyc;
        bit checked;
        string tag;
        tag = $sformatf("rand%0d", id);
        do_reset();
        for (int i = 0; i < nbytes; i++) msg.push_back(8'($urandom));
        nfull = nbytes / 4;
        last_nb = 2'(nbytes % 4);
        for (int i = 0; i < nfull; i++)
            words.push_back({msg[4*i], msg[4*i+1], msg[4*i+2], msg[4*i+3]});
        begin
            logic [31:0] lw;
            lw = $urandom;
            for (int j = 0; j < int'(last_nb); j++) lw[31-8*j -: 8] = msg[4*nfull+j];
            words.push_back(lw);
        end
        padded = msg;
        padded.push_back(8'h06);
        while (padded.size() % 72 != 0) padded.push_back(8'h00);
        padded[padded.size()-1] = padded[padded.size()-1] | 8'h80;
        nblk = padded.size() / 72;

        wi = 0; blk = 0; delay = 0; cyc = 0; checked = 0;
        while (blk < nblk && cyc < 5000) begin
            idle_inputs();
            if (out_ready) begin
                if (!checked) begin
                    for (int j = 0; j < 72; j++) eb[575-8*j -: 8] = padded[blk*72+j];
                    check($sformatf("%s_blk%0d", tag, blk), dout, eb);
                    check($sformatf("%s_lastflag%0d", tag, blk), last_block, (blk == nblk-1));
                    checked = 1;
                    delay = $urandom_range(0, 3);
                end
                if (delay == 0) begin
                    f_ack = 1'b1;
                    blk++;
                    checked = 0;
                end else begin
                    delay--;
                end
            end else if (wi <= nfull && !buffer_full && $urandom_range(0, 3) != 0) begin
                din = words[wi];
                in_ready = 1'b1;
                is_last = (wi == nfull);
                nb = (wi == nfull) ? last_nb : 2'd0;
                wi++;
            end
            tick();
            cyc++;
        end
        idle_inputs();
        check({tag, "_timeout"}, (cyc < 5000), 1'b1);
        check({tag, "_done"}, {out_ready, buffer_full}, 2'b01);
    endtask

    initial begin
        vec_t vecs[7];
        logic [575:0] exp;
        int lat;

        n_pass = 0;
        n_total = 0;
        rst = 1'b0;
        idle_inputs();

        vecs[0] = '{k: 0,  data: 32'hFFFFFFFF, nb: 2'd0, exp_k: 32'h06000000, exp_17: 32'h00000080, exp_lat: 18};
        vecs[1] = '{k: 0,  data: 32'h61626300, nb: 2'd3, exp_k: 32'h61626306, exp_17: 32'h00000080, exp_lat: 18};
        vecs[2] = '{k: 17, data: 32'hAABBCC00, nb: 2'd3, exp_k: 32'hAABBCC86, exp_17: 32'hAABBCC86, exp_lat: 1};
        vecs[3] = '{k: 17, data: 32'h12345678, nb: 2'd0, exp_k: 32'h06000080, exp_17: 32'h06000080, exp_lat: 1};
        vecs[4] = '{k: 5,  data: 32'h11223344, nb: 2'd1, exp_k: 32'h11060000, exp_17: 32'h00000080, exp_lat: 13};
        vecs[5] = '{k: 16, data: 32'hDEADBEEF, nb: 2'd2, exp_k: 32'hDEAD0600, exp_17: 32'h00000080, exp_lat: 2};
        vecs[6] = '{k: 17, data: 32'hCAFEBABE, nb: 2'd1, exp_k: 32'hCA060080, exp_17: 32'hCA060080, exp_lat: 1};

        // reset state
        do_reset();
        check("reset_out", dout, '0);
        check("reset_flags", {out_ready, last_block, buffer_full}, 3'b000);

        for (int i = 0; i < 7; i++) run_entry(vecs[i], i);

        // full non-last block with back-pressure, ack, then an empty final block
        do_reset();
        exp = '0;
        for (int i = 0; i < 18; i++) begin
            din = fill(i); in_ready = 1'b1; is_last = 1'b0;
            exp[575-32*i -: 32] = fill(i);
            tick();
        end
        idle_inputs();
        check("bp_flags", {out_ready, last_block, buffer_full}, 3'b101);
        check("bp_block", dout, exp);
        for (int c = 0; c < 5; c++) begin
            din = $urandom; in_ready = 1'b1;
            tick();
        end
        check("bp_stable", dout, exp);
        check("bp_still_ready", out_ready, 1'b1);
        din = 32'hBAD0BAD0; in_ready = 1'b1; f_ack = 1'b1;
        tick();
        idle_inputs();
        check("bp_after_ack", {out_ready, buffer_full}, 2'b00);
        din = 32'h77777777; nb = 2'd0; is_last = 1'b1; in_ready = 1'b1;
        tick();
        idle_inputs();
        wait_ready(lat);
        check("bp2_latency", lat, 18);
        exp = '0;
        exp[575:568] = 8'h06;
        exp[7:0] = 8'h80;
        check("bp2_block", dout, exp);
        check("bp2_last_block", last_block, 1'b1);
        f_ack = 1'b1;
        tick();
        idle_inputs();
        check("bp2_done", {out_ready, buffer_full}, 2'b01);

        // reset while padding
        do_reset();
        nb = 2'd0; is_last = 1'b1; in_ready = 1'b1;
        tick();
        idle_inputs();
        for (int c = 0; c < 5; c++) tick();
        check("pad_busy", {out_ready, buffer_full}, 2'b01);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("padrst_out", dout, '0);
        check("padrst_flags", {out_ready, last_block, buffer_full}, 3'b000);
        din = 32'h61626300; nb = 2'd3; is_last = 1'b1; in_ready = 1'b1;
        tick();
        idle_inputs();
        wait_ready(lat);
        check("padrst_latency", lat, 18);
        exp = '0;
        exp[575:544] = 32'h61626306;
        exp[31:0] = 32'h00000080;
        check("padrst_block", dout, exp);

        // randomized messages against the byte-stream model
        for (int r = 0; r < 20; r++) run_random($urandom_range(0, 220), r);
        run_random(71, 20);
        run_random(72, 21);
        run_random(144, 22);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
